// File: rtl/dkong_obj_dma_pkg.sv
// Shared types and widths for the object-RAM DMA initiator.
//   dma_state_t : FSM state encoding
//   OBJ_RAM_AW  : object RAM offset width
//   Z80_AW      : CPU bus address width
package dkong_pkg;

   localparam int OBJ_RAM_AW = 10;
   localparam int Z80_AW     = 16;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      RD,
      WR,
      NEXT,
      REL
   } dma_state_t;

endpackage

// File: rtl/dkong_obj_dma_if.sv
// Bus seen by the DMA initiator: CPU bus request/grant, work-RAM read port and
// the dkong_video object-RAM write port.
//   master : the DMA engine (drives address, strobes, write data, busrq_n)
//   slave  : CPU arbiter + memories (drive busak_n, read data, vram_busy)
interface dkong_obj_dma_if;

   logic                        busrq_n;
   logic                        busak_n;
   logic [dkong_pkg::Z80_AW-1:0] addr;
   logic [7:0]                  dmaster;
   logic [7:0]                  dslave;
   logic                        rdn;
   logic                        wrn;
   logic                        obj_ena;
   logic                        vram_busy;

   modport master (
      output busrq_n, addr, dmaster, rdn, wrn, obj_ena,
      input  busak_n, dslave, vram_busy
   );

   modport slave (
      input  busrq_n, addr, dmaster, rdn, wrn, obj_ena,
      output busak_n, dslave, vram_busy
   );

endinterface

// File: rtl/dkong_obj_dma.sv
// Sprite-list DMA: on start, takes the CPU bus and copies LEN bytes from work
// RAM (SRC_BASE..) into dkong_video object RAM (DST_BASE..), one read + one
// write per byte, waiting out vram_busy before each write.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   start       : one-cycle trigger, only honoured in IDLE
//   busy        : transfer in progress
//   done        : one-cycle completion pulse (in the REL->IDLE cycle)
//   bus         : master side of dkong_obj_dma_if
//
// state | meaning
// IDLE  | waiting for start
// REQ   | busrq_n low, waiting for busak_n
// RD    | rdn low for RD_LAT+1 cycles, byte latched on the last one
// WR    | waits while vram_busy, then one-cycle write strobe
// NEXT  | advance src/dst/count, loop or finish
// REL   | busrq_n high, waiting for busak_n to return high
module dkong_obj_dma
   import dkong_pkg::*;
#(
   parameter logic [Z80_AW-1:0]     SRC_BASE = 16'h6900,
   parameter logic [OBJ_RAM_AW-1:0] DST_BASE = 10'h000,
   parameter logic [OBJ_RAM_AW-1:0] LEN      = 10'h180,
   parameter int                    RD_LAT   = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            busy,
   output logic            done,
   dkong_obj_dma_if.master bus
);

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

   dma_state_t            state, state_nxt;
   logic [Z80_AW-1:0]     src;
   logic [OBJ_RAM_AW-1:0] dst;
   logic [OBJ_RAM_AW-1:0] cnt;
   logic [1:0]            lat;
   logic [7:0]            data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src  <= '0;
         dst  <= '0;
         cnt  <= '0;
         lat  <= '0;
         data <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               cnt <= '0;
               src <= SRC_BASE;
               dst <= DST_BASE;
            end
            RD: begin
               // lat is 0 on entry to every RD, so the read length is fixed
               if (lat == LAT_LAST) begin
                  data <= bus.dslave;
                  lat  <= '0;
               end else begin
                  lat <= lat + 2'd1;
               end
            end
            NEXT: begin
               src <= src + Z80_AW'(1);
               dst <= dst + OBJ_RAM_AW'(1);
               cnt <= cnt + OBJ_RAM_AW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt   = state;
      busy        = (state != IDLE);
      done        = 1'b0;
      bus.busrq_n = 1'b1;
      bus.addr    = '0;
      bus.dmaster = '0;
      bus.rdn     = 1'b1;
      bus.wrn     = 1'b1;
      bus.obj_ena = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = REQ;
         REQ: begin
            bus.busrq_n = 1'b0;
            if (!bus.busak_n) state_nxt = RD;
         end
         RD: begin
            bus.busrq_n = 1'b0;
            bus.addr    = src;
            bus.rdn     = 1'b0;
            if (lat == LAT_LAST) state_nxt = WR;
         end
         WR: begin
            bus.busrq_n = 1'b0;
            if (!bus.vram_busy) begin
               bus.addr    = {{(Z80_AW-OBJ_RAM_AW){1'b0}}, dst};
               bus.dmaster = data;
               bus.wrn     = 1'b0;
               bus.obj_ena = 1'b1;
               state_nxt   = NEXT;
            end
         end
         NEXT: begin
            bus.busrq_n = 1'b0;
            state_nxt   = ((cnt + OBJ_RAM_AW'(1)) == LEN) ? REL : RD;
         end
         REL: if (bus.busak_n) begin
            done      = 1'b1;
            busy      = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dkong_obj_dma.sv
module tb_dkong_obj_dma;

   logic clk = 1'b0;
   logic rst_n;
   logic start [2];
   int   ga_dly [2];
   int   stall_at [2];
   logic [7:0] mem [65536];

   int total = 0;
   int bad   = 0;
   int s_rb, s_wb, s_dc, s_ac, s_pr, s_rw, s_vi;

   always #8 clk = ~clk;

   dkong_obj_dma_if bus[2] ();

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam logic [15:0] SRC = (g == 0) ? 16'h6900 : 16'hFFFE;
      localparam logic [9:0]  DST = (g == 0) ? 10'h000 : 10'h3FE;
      localparam logic [9:0]  LN  = (g == 0) ? 10'h180 : 10'd4;
      localparam int          LAT = (g == 0) ? 1 : 3;

      logic busy, done;
      logic [15:0] rd_q [$];
      logic [9:0]  wa_q [$];
      logic [7:0]  wd_q [$];
      int   rd_run = 0, ak_cnt = 0, stall_left = 0;
      int   done_cnt = 0, viol = 0, act_cyc = 0, req_wait = 0, pre_rd = 0;
      logic prev_rdn = 1'b1, rose = 1'b0, rd_seen = 1'b0;

      dkong_obj_dma #(.SRC_BASE(SRC), .DST_BASE(DST), .LEN(LN), .RD_LAT(LAT)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .start (start[g]),
         .busy  (busy),
         .done  (done),
         .bus   (bus[g])
      );

      // CPU arbiter, work RAM and video responder, driven just after each edge
      always @(posedge clk) begin
         #1;
         if (!rst_n) begin
            bus[g].busak_n   = 1'b1;
            bus[g].vram_busy = 1'b0;
            bus[g].dslave    = 8'h00;
            prev_rdn = 1'b1; rd_run = 0; ak_cnt = 0; stall_left = 0;
         end else begin
            rose = bus[g].rdn && !prev_rdn;
            if (!bus[g].rdn) begin
               if (prev_rdn) begin
                  rd_run = 0;
                  rd_q.push_back(bus[g].addr);
               end else begin
                  rd_run++;
               end
            end
            prev_rdn = bus[g].rdn;
            // data is only valid RD_LAT cycles after rdn falls; before that it is corrupted
            bus[g].dslave = (!bus[g].rdn && rd_run >= LAT) ? mem[bus[g].addr] : ~mem[bus[g].addr];
            if (bus[g].busrq_n == bus[g].busak_n) ak_cnt = 0;
            else begin
               ak_cnt++;
               if (ak_cnt > (bus[g].busrq_n ? 3 : ga_dly[g])) bus[g].busak_n = bus[g].busrq_n;
            end
            if (stall_left > 0) begin
               stall_left--;
               if (stall_left == 0) bus[g].vram_busy = 1'b0;
            end else if (rose && rd_q.size() == stall_at[g]) begin
               bus[g].vram_busy = 1'b1;
               stall_left = 20;
            end
         end
      end

      always @(negedge clk) begin
         if (rst_n) begin
            if (!bus[g].wrn) begin
               wa_q.push_back(bus[g].addr[9:0]);
               wd_q.push_back(bus[g].dmaster);
            end
            if (!bus[g].rdn && (!bus[g].wrn || bus[g].obj_ena)) viol++;
            if (bus[g].wrn != !bus[g].obj_ena) viol++;
            if (bus[g].vram_busy && !bus[g].wrn) viol++;
            if (!bus[g].wrn && bus[g].addr[15:10] != 6'd0) viol++;
            if (bus[g].busrq_n && (!bus[g].rdn || !bus[g].wrn)) viol++;
            if (bus[g].busak_n && !bus[g].rdn) viol++;
            if (bus[g].rdn && bus[g].wrn && (bus[g].addr != 16'd0 || bus[g].dmaster != 8'd0)) viol++;
            if (done) done_cnt++;
            if (!bus[g].busrq_n && !bus[g].busak_n && !rd_seen && bus[g].rdn) pre_rd++;
            if (bus[g].busrq_n) rd_seen = 1'b0;
            else if (!bus[g].rdn) rd_seen = 1'b1;
            if (!bus[g].busrq_n && rd_seen) act_cyc++;
            if (!bus[g].busrq_n && bus[g].busak_n) req_wait++;
         end
      end
   end

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: byte i comes from src+i (mod 64K) and lands at dst+i (mod 1K), in order.
   task automatic check_xfer(input string tag, input logic [15:0] rq[$], input logic [9:0] aq[$],
                             input logic [7:0] dq[$], input int rb, input int wb,
                             input logic [15:0] src, input logic [9:0] dst, input int len);
      cmp({tag, " reads"}, 32'(rq.size() - rb), 32'(len));
      cmp({tag, " writes"}, 32'(aq.size() - wb), 32'(len));
      for (int i = 0; i < len; i++) begin
         if (rb + i < rq.size())
            cmp($sformatf("%s ra[%0d]", tag, i), 32'(rq[rb+i]), 32'(16'(src + i)));
         if (wb + i < aq.size()) begin
            cmp($sformatf("%s wa[%0d]", tag, i), 32'(aq[wb+i]), 32'(10'(dst + i)));
            cmp($sformatf("%s wd[%0d]", tag, i), 32'(dq[wb+i]), 32'(mem[16'(src + i)]));
         end
      end
   endtask

   task automatic snap;
      s_rb = g_dut[0].rd_q.size();
      s_wb = g_dut[0].wa_q.size();
      s_dc = g_dut[0].done_cnt;
      s_ac = g_dut[0].act_cyc;
      s_pr = g_dut[0].pre_rd;
      s_rw = g_dut[0].req_wait;
      s_vi = g_dut[0].viol;
   endtask

   task automatic check_a(input string tag, input int exp_act);
      check_xfer(tag, g_dut[0].rd_q, g_dut[0].wa_q, g_dut[0].wd_q, s_rb, s_wb, 16'h6900, 10'h000, 384);
      cmp({tag, " done"}, 32'(g_dut[0].done_cnt - s_dc), 32'd1);
      cmp({tag, " cycles"}, 32'(g_dut[0].act_cyc - s_ac), 32'(exp_act));
      cmp({tag, " protocol"}, 32'(g_dut[0].viol - s_vi), 32'd0);
   endtask

   task automatic pulse0;
      @(posedge clk); #1 start[0] = 1'b1;
      @(posedge clk); #1 start[0] = 1'b0;
   endtask

   // mode 1: start during the done cycle (must be ignored); mode 2: start the cycle after
   task automatic wait_done(input int mode, input int budget);
      int d0 = g_dut[0].done_cnt;
      int n = 0;
      while (g_dut[0].done_cnt == d0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      cmp("done within budget", 32'(n < budget), 32'd1);
      if (mode == 1) begin
         start[0] = 1'b1;
         @(posedge clk); #1 start[0] = 1'b0;
      end else if (mode == 2) begin
         @(posedge clk); #1 start[0] = 1'b1;
         @(posedge clk); #1 start[0] = 1'b0;
      end
   endtask

   initial begin
      int n, rbb, wbb, dcb, acb;
      rst_n = 1'b0;
      start[0] = 1'b0; start[1] = 1'b0;
      ga_dly[0] = 3; ga_dly[1] = 3;
      stall_at[0] = -1; stall_at[1] = -1;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

      repeat (2) @(posedge clk);
      #2;
      for (int g = 0; g < 2; g++) begin
         cmp("rst busrq_n", (g == 0) ? bus[0].busrq_n : bus[1].busrq_n, 1);
         cmp("rst rdn",     (g == 0) ? bus[0].rdn     : bus[1].rdn, 1);
         cmp("rst wrn",     (g == 0) ? bus[0].wrn     : bus[1].wrn, 1);
         cmp("rst obj_ena", (g == 0) ? bus[0].obj_ena : bus[1].obj_ena, 0);
         cmp("rst addr",    (g == 0) ? bus[0].addr    : bus[1].addr, 0);
         cmp("rst dmaster", (g == 0) ? bus[0].dmaster : bus[1].dmaster, 0);
         cmp("rst busy",    (g == 0) ? g_dut[0].busy  : g_dut[1].busy, 0);
         cmp("rst done",    (g == 0) ? g_dut[0].done  : g_dut[1].done, 0);
      end
      @(negedge clk); rst_n = 1'b1;

      // basic transfer, grant after 3 cycles
      snap();
      pulse0();
      wait_done(0, 2500);
      check_a("basic", 1536);
      cmp("basic grant", 32'(g_dut[0].pre_rd - s_pr), 32'd1);
      repeat (6) @(posedge clk);
      #1 cmp("basic released", bus[0].busrq_n, 1);

      // vram_busy stall on byte 5
      ga_dly[0] = $urandom_range(1, 8);
      snap();
      stall_at[0] = s_rb + 6;
      pulse0();
      wait_done(0, 2500);
      stall_at[0] = -1;
      check_a("stall", 1536 + 20);
      repeat (6) @(posedge clk);

      // grant latency, then start during the done cycle is ignored
      ga_dly[0] = 50;
      snap();
      pulse0();
      wait_done(1, 2500);
      check_a("grant", 1536);
      cmp("grant wait", 32'(g_dut[0].req_wait - s_rw), 32'd50);
      cmp("grant first read", 32'(g_dut[0].pre_rd - s_pr), 32'd1);
      repeat (10) @(posedge clk);
      #1;
      cmp("done-cycle start ignored busy", g_dut[0].busy, 0);
      cmp("done-cycle start ignored busrq_n", bus[0].busrq_n, 1);
      cmp("done-cycle start ignored done", 32'(g_dut[0].done_cnt - s_dc), 32'd1);

      // retrigger in REQ and mid-RD; then start right after done is accepted
      ga_dly[0] = 5;
      snap();
      pulse0();
      repeat (1) @(posedge clk);
      pulse0();
      n = 0;
      while (bus[0].rdn && n < 100) begin @(negedge clk); #1; n++; end
      cmp("retrigger rd seen", 32'(n < 100), 32'd1);
      pulse0();
      wait_done(2, 2500);
      check_a("retrigger", 1536);
      snap();
      cmp("next-cycle start accepted", g_dut[0].busy, 1);

      // reset during the write of byte 100
      n = 0;
      while (!(g_dut[0].rd_q.size() - s_rb == 101 && bus[0].rdn) && n < 1000) begin
         @(negedge clk); n++;
      end
      cmp("byte100 reached", 32'(n < 1000), 32'd1);
      #1 cmp("byte100 in write", bus[0].wrn, 0);
      #1 rst_n = 1'b0;
      #1;
      cmp("midrst busrq_n", bus[0].busrq_n, 1);
      cmp("midrst wrn", bus[0].wrn, 1);
      cmp("midrst obj_ena", bus[0].obj_ena, 0);
      cmp("midrst rdn", bus[0].rdn, 1);
      cmp("midrst busy", g_dut[0].busy, 0);
      cmp("midrst addr", bus[0].addr, 0);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      ga_dly[0] = 3;
      snap();
      pulse0();
      wait_done(0, 2500);
      check_a("restart", 1536);

      // address wrap with RD_LAT=3
      rbb = g_dut[1].rd_q.size();
      wbb = g_dut[1].wa_q.size();
      dcb = g_dut[1].done_cnt;
      acb = g_dut[1].act_cyc;
      @(posedge clk); #1 start[1] = 1'b1;
      @(posedge clk); #1 start[1] = 1'b0;
      n = 0;
      while (g_dut[1].done_cnt == dcb && n < 300) begin @(negedge clk); #1; n++; end
      cmp("wrap done within budget", 32'(n < 300), 32'd1);
      check_xfer("wrap", g_dut[1].rd_q, g_dut[1].wa_q, g_dut[1].wd_q, rbb, wbb, 16'hFFFE, 10'h3FE, 4);
      cmp("wrap cycles", 32'(g_dut[1].act_cyc - acb), 32'd24);
      cmp("wrap protocol", 32'(g_dut[1].viol), 32'd0);

      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dkong_obj_dma.md
Name: dkong_obj_dma

Overview:
- Sprite-list DMA initiator: on a CPU trigger, copies LEN bytes from CPU work RAM into dkong_video object RAM.
- It is the bus master that writes obj RAM through dkong_video's ibus/obj_ena port, honouring vram_busy. The video block is the responder.
- It sits between the CPU bus arbiter (BUSRQ/BUSAK) and the memory map, and replaces CPU-driven object writes.

Parameters:
- SRC_BASE, 16'h6900, first source address in work RAM.
- DST_BASE, 10'h000, first destination offset in object RAM.
- LEN, 10'h180, bytes per transfer; legal range 1..1023.
- RD_LAT, 1, cycles from rdn falling to valid read data; legal range 1..3.

Ports:
- clk  in  1  system clock (61.44 MHz).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle trigger decoded from the DMA start register write.
- busrq_n  out  1  bus request to the CPU, active low.
- busak_n  in  1  bus acknowledge from the CPU, active low.
- addr  out  16  master address (source address during read, destination offset zero-extended during write).
- dmaster  out  8  write data.
- dslave  in  8  read data from work RAM.
- rdn  out  1  read strobe, active low.
- wrn  out  1  write strobe, active low.
- obj_ena  out  1  object-RAM chip enable into dkong_video.
- vram_busy  in  1  dkong_video is scanning object RAM; writes must wait.
- busy  out  1  a transfer is in progress.
- done  out  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset (async, applied immediately, including mid-transfer):
  - busrq_n=1, rdn=1, wrn=1, obj_ena=0, busy=0, done=0, addr=0, dmaster=0.
  - FSM returns to IDLE and the byte counter clears.
- Bus-off rule: whenever the FSM is not in RD or WR, outputs are addr=0, dmaster=0, rdn=1, wrn=1, obj_ena=0.
- FSM states:
  - IDLE: busy=0. If start=1, clear counter and latch src=SRC_BASE, dst=DST_BASE, then go to REQ. start is ignored in every other state.
  - REQ: busrq_n=0, busy=1. Stay until busak_n=0, then go to RD.
  - RD: addr=src, rdn=0 for RD_LAT+1 cycles. dslave is latched into the data register on the last of those cycles. Then go to WR.
  - WR: hold wrn=1 and obj_ena=0 while vram_busy=1. In the first cycle with vram_busy=0, drive addr={6'b0,dst}, dmaster=latched byte, wrn=0, obj_ena=1 for exactly that cycle, then go to NEXT.
  - NEXT (1 cycle): src+=1 (wraps mod 2^16), dst+=1 (wraps mod 1024), count+=1. If count+1==LEN go to REL, else go to RD.
  - REL: busrq_n=1. Stay until busak_n=1. Then pulse done=1 for one cycle, set busy=0, and go to IDLE.
- Cycle count with no stalls: each byte takes RD_LAT+3 cycles. With RD_LAT=1 and LEN=h180, the transfer takes 1536 cycles plus REQ and REL time.
- vram_busy stall:
  - Only a sampled vram_busy=1 in WR holds the FSM.
  - Read data stays held in the data register during the stall.
  - The read is never reissued.
- busak_n rising before REL is a CPU protocol violation. Ignore it; the transfer continues.
- start coinciding with done (REL→IDLE cycle) is ignored. start in the following cycle is accepted.
- obj_ena and wrn are never low together with rdn.

Decomposition:
- Shared package dkong_pkg:
  - dma_state_t enum (IDLE, REQ, RD, WR, NEXT, REL).
  - Constants OBJ_RAM_AW=10, Z80_AW=16.
- No sub-module: single FSM plus counters.

Test Plan:
- Basic transfer:
  - Stimulus: work RAM model holds byte[i]=i^8'h5A at 6900+i; start pulse; busak_n follows busrq_n after 3 cycles; vram_busy=0.
  - Response: 384 writes with obj_ena=1 at offsets 000..17F carrying the matching data, then busrq_n=1, then exactly one done pulse.
- vram_busy stall:
  - Stimulus: hold vram_busy=1 for 20 cycles starting at the WR of byte 5.
  - Response: no wrn/obj_ena assertion during the stall; byte 5 data unchanged when written; total length grows by exactly 20 cycles.
- Busy retrigger:
  - Stimulus: start pulses in REQ and mid-RD.
  - Response: still exactly 384 writes and one done; no restart.
- Reset mid-transfer:
  - Stimulus: drop rst_n during the WR of byte 100.
  - Response: in the same cycle busrq_n=1, wrn=1, obj_ena=0, busy=0. After release and a new start, writes restart at offset 000.
- Wrap and RD_LAT:
  - Stimulus: RD_LAT=3, SRC_BASE=FFFE, DST_BASE=3FE, LEN=4.
  - Response: reads at FFFE, FFFF, 0000, 0001; writes at 3FE, 3FF, 000, 001; each byte takes 6 cycles.
- Grant latency:
  - Stimulus: busak_n held high for 50 cycles after busrq_n falls.
  - Response: rdn stays 1 for all 50 cycles; the first read starts the cycle after busak_n=0 is sampled.
